gb_cpu_mcycle_sequencer: RTL
============================

Name: gb_cpu_mcycle_sequencer

Overview:
- Parametrised successor to the fixed three-slot instruction scheduler.
- Accepts a decoded instruction schedule through a valid/ready handshake, then steps through up to MAX_M_CYCLES control words, one per M-cycle.
- Supports stall, conditional early termination, back-to-back schedules and CB-prefix tracking.
- Sits between the decoder and the datapath control register.

Parameters:
- MAX_M_CYCLES, 6, number of control slots per schedule (at least 2).
- CTRL_W, 32, width of one flattened control word.
- CNT_W, $clog2(MAX_M_CYCLES), width of the slot index and count fields.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- sched_valid  input  1  schedule offered
- sched_ready  output  1  sequencer can accept a schedule this cycle
- sched_m_cycles  input  CNT_W  last slot index N; schedule runs N+1 M-cycles
- sched_ctrl  input  MAX_M_CYCLES*CTRL_W  slot k occupies bits [k*CTRL_W +: CTRL_W]
- sched_cond_en  input  1  schedule contains a condition check
- sched_cond_idx  input  CNT_W  slot at which the condition is evaluated
- sched_cb_prefix  input  1  schedule is a CB prefix fetch
- cond_not_met  input  1  condition result from the ALU flags
- stall  input  1  memory wait; hold the current slot
- ctrl_o  output  CTRL_W  current control word
- ctrl_valid_o  output  1  ctrl_o is meaningful
- m_cycle_o  output  CNT_W  current slot index
- last_cycle_o  output  1  current slot is final (combinational)
- cb_prefix_o  output  1  next opcode decodes from the CB table

Behaviour:
- Reset (synchronous, active-high, overrides everything including mid-schedule):
  - state=IDLE, ctrl_o=0, ctrl_valid_o=0, m_cycle_o=0, cb_prefix_o=0.
  - Latched schedule is discarded.
- States: IDLE and EXEC.
- Schedule latch: on acceptance, all sched_* fields are stored.
  - N = min(sched_m_cycles, MAX_M_CYCLES-1).
  - A cond_idx greater than N disables the condition.
- IDLE:
  - sched_ready=1, ctrl_valid_o=0.
  - Accept when sched_valid=1. Next cycle: EXEC, m_cycle_o=0, ctrl_o=slot0, ctrl_valid_o=1. Latency from accept to first control word is 1 cycle.
- last_cycle_o = EXEC & (m_cycle_o==N | (cond_en & m_cycle_o==cond_idx & cond_not_met)).
- sched_ready = IDLE | (last_cycle_o & ~stall). This is a combinational path from cond_not_met and stall.
- EXEC with stall=1:
  - m_cycle_o and ctrl_o hold; no acceptance.
  - A condition abort is not taken while stalled; cond_not_met is re-evaluated on the first unstalled cycle.
- EXEC, stall=0, not last: m_cycle_o+1, ctrl_o=next slot.
- EXEC, stall=0, last:
  - Retire: cb_prefix_o <= latched cb_prefix.
  - If sched_valid=1, the new schedule is accepted and slot0 appears next cycle with no bubble. m_cycle_o does not wrap past N; it restarts at 0.
  - Otherwise go to IDLE with ctrl_valid_o=0; ctrl_o holds its last value.
- Condition abort retires immediately; remaining slots are skipped.
- cb_prefix_o holds between retirements and changes only at retire.
- Schedule with N=0: a single-cycle schedule; last_cycle_o=1 in its only cycle.
- sched_valid in EXEC on a non-last cycle is ignored; the source must hold the schedule.

Optional Feature:
- Macro: GB_CPU_SEQ_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - retired_cnt_o [15:0]: increments on each retirement.
  - stall_cnt_o [15:0]: increments on each EXEC cycle with stall=1.
  - Both counters saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and their logic are absent and the behaviour is otherwise identical.

Test Plan:
- Reset, then offer N=2 with slots 0x11/0x22/0x33 and no stall -> ctrl_o reads 0x11,0x22,0x33 over 3 cycles, then ctrl_valid_o=0; last_cycle_o=1 only on 0x33.
- Back-to-back: second schedule N=1 (0xAA,0xBB) valid during the first schedule's last cycle -> sequence 0x11,0x22,0x33,0xAA,0xBB with no bubble.
- Condition: N=4, cond_en=1, cond_idx=1, cond_not_met=1 at slot 1 -> retires after 2 cycles, sched_ready=1 at slot 1; with cond_not_met=0 all 5 slots execute.
- Stall: stall=1 for 3 cycles at slot 1 of N=2 -> slot 1 visible for 4 cycles, sched_ready=0 throughout the stall, total 6 cycles; with the macro, stall_cnt_o=3.
- CB prefix: schedule with cb_prefix=1, N=0 -> cb_prefix_o rises the cycle after retirement and stays 1 until the next schedule retires with cb_prefix=0.
- Reset asserted at slot 3 of N=5 -> next cycle IDLE, ctrl_valid_o=0, m_cycle_o=0, cb_prefix_o=0; a new schedule is accepted normally afterwards.

Source files
------------

// File: rtl/gb_cpu_mcycle_sequencer.sv
// M-cycle sequencer: latches a decoded schedule and steps one control word per M-cycle.
// Optional performance counters are enabled with `define GB_CPU_SEQ_PERF_CNT_EN.
module gb_cpu_mcycle_sequencer #(
    parameter int MAX_M_CYCLES = 6,
    parameter int CTRL_W       = 32,
    parameter int CNT_W        = $clog2(MAX_M_CYCLES)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sched_valid,
    output logic                           sched_ready,
    input  logic [CNT_W-1:0]               sched_m_cycles,
    input  logic [MAX_M_CYCLES*CTRL_W-1:0] sched_ctrl,
    input  logic                           sched_cond_en,
    input  logic [CNT_W-1:0]               sched_cond_idx,
    input  logic                           sched_cb_prefix,
    input  logic                           cond_not_met,
    input  logic                           stall,
    output logic [CTRL_W-1:0]              ctrl_o,
    output logic                           ctrl_valid_o,
    output logic [CNT_W-1:0]               m_cycle_o,
    output logic                           last_cycle_o,
    output logic                           cb_prefix_o
`ifdef GB_CPU_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]                    retired_cnt_o,
    output logic [15:0]                    stall_cnt_o
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_M_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDX_ONE  = CNT_W'(1);

    state_t                           state_q, state_d;
    logic [CTRL_W-1:0]                ctrl_q, ctrl_d;
    logic [CNT_W-1:0]                 m_cycle_q, m_cycle_d;
    logic                             cb_prefix_q, cb_prefix_d;
    logic [MAX_M_CYCLES*CTRL_W-1:0]   sched_buf_q, sched_buf_d;
    logic [CNT_W-1:0]                 n_q, n_d;
    logic                             cond_en_q, cond_en_d;
    logic [CNT_W-1:0]                 cond_idx_q, cond_idx_d;
    logic                             cb_lat_q, cb_lat_d;

    logic                             last_s;
    logic                             retire_s;
    logic                             ready_s;
    logic                             accept_s;
    logic [CNT_W-1:0]                 n_new_s;
    logic [CNT_W-1:0]                 m_next_s;

    // Last-slot detection and handshake; a stalled last slot neither retires nor accepts.
    always_comb begin
        last_s   = 1'b0;
        if (state_q == S_EXEC) begin
            last_s = (m_cycle_q == n_q) ||
                     (cond_en_q && (m_cycle_q == cond_idx_q) && cond_not_met);
        end else begin
            last_s = 1'b0;
        end
        retire_s = (state_q == S_EXEC) && last_s && !stall;
        ready_s  = (state_q == S_IDLE) || retire_s;
        accept_s = sched_valid && ready_s;
        n_new_s  = (sched_m_cycles > LAST_IDX) ? LAST_IDX : sched_m_cycles;
        m_next_s = m_cycle_q + IDX_ONE;
    end

    // Next-state: accept, retire to idle, advance, or hold.
    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        m_cycle_d   = m_cycle_q;
        cb_prefix_d = cb_prefix_q;
        sched_buf_d = sched_buf_q;
        n_d         = n_q;
        cond_en_d   = cond_en_q;
        cond_idx_d  = cond_idx_q;
        cb_lat_d    = cb_lat_q;

        if (accept_s) begin
            state_d     = S_EXEC;
            m_cycle_d   = '0;
            ctrl_d      = sched_ctrl[CTRL_W-1:0];
            sched_buf_d = sched_ctrl;
            n_d         = n_new_s;
            cond_en_d   = sched_cond_en && (sched_cond_idx <= n_new_s);
            cond_idx_d  = sched_cond_idx;
            cb_lat_d    = sched_cb_prefix;
        end else if (retire_s) begin
            state_d   = S_IDLE;
            m_cycle_d = '0;
        end else if ((state_q == S_EXEC) && !stall) begin
            m_cycle_d = m_next_s;
            ctrl_d    = sched_buf_q[int'(m_next_s)*CTRL_W +: CTRL_W];
        end else begin
            state_d = state_q;
        end

        if (retire_s) begin
            cb_prefix_d = cb_lat_q;
        end else begin
            cb_prefix_d = cb_prefix_q;
        end
    end

    // State and schedule registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ctrl_q      <= '0;
            m_cycle_q   <= '0;
            cb_prefix_q <= 1'b0;
            sched_buf_q <= '0;
            n_q         <= '0;
            cond_en_q   <= 1'b0;
            cond_idx_q  <= '0;
            cb_lat_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            m_cycle_q   <= m_cycle_d;
            cb_prefix_q <= cb_prefix_d;
            sched_buf_q <= sched_buf_d;
            n_q         <= n_d;
            cond_en_q   <= cond_en_d;
            cond_idx_q  <= cond_idx_d;
            cb_lat_q    <= cb_lat_d;
        end
    end

    assign sched_ready  = ready_s;
    assign last_cycle_o = last_s;
    assign ctrl_o       = ctrl_q;
    assign ctrl_valid_o = (state_q == S_EXEC);
    assign m_cycle_o    = m_cycle_q;
    assign cb_prefix_o  = cb_prefix_q;

`ifdef GB_CPU_SEQ_PERF_CNT_EN
    logic [15:0] retired_cnt_q, retired_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating retirement and stall counters.
    always_comb begin
        retired_cnt_d = retired_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        if (retire_s && (retired_cnt_q != 16'hFFFF)) begin
            retired_cnt_d = retired_cnt_q + 16'd1;
        end else begin
            retired_cnt_d = retired_cnt_q;
        end
        if ((state_q == S_EXEC) && stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_cnt_q <= 16'd0;
            stall_cnt_q   <= 16'd0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign retired_cnt_o = retired_cnt_q;
    assign stall_cnt_o   = stall_cnt_q;
`endif

endmodule
